// File: rtl/sram_controller.sv
// Sequences single-word read, write and copy requests onto a single-port
// synchronous SRAM whose read latency is set by RD_LAT. Read data is kept on data_out.
module sram_controller #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req,
  input  logic [1:0]        op_code,
  input  logic [ADDR_W-1:0] address_one,
  input  logic [ADDR_W-1:0] address_two,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_COPY  = 2'b11;
  localparam int         CNT_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    DONE
  } state_t;

  state_t              state_reg;
  logic [1:0]          op_reg;
  logic [ADDR_W-1:0]   addr_one_reg;
  logic [ADDR_W-1:0]   addr_two_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rbuf_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                is_copy;

  assign is_copy = (op_reg == OP_COPY);

  // SRAM bus is decoded from state and latched fields only, so req never
  // reaches it combinationally and it reads all-zero outside the issue states.
  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_reg)
      RD_ISSUE: begin
        mem_ren  = 1'b1;
        mem_addr = addr_one_reg;
      end
      WR_ISSUE: begin
        mem_wen   = 1'b1;
        mem_addr  = is_copy ? addr_two_reg : addr_one_reg;
        mem_wdata = is_copy ? rbuf_reg : wdata_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg    <= IDLE;
      op_reg       <= OP_NOP;
      addr_one_reg <= '0;
      addr_two_reg <= '0;
      wdata_reg    <= '0;
      rbuf_reg     <= '0;
      cnt_reg      <= '0;
      data_out     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req && op_code != OP_NOP) begin
            op_reg       <= op_code;
            addr_one_reg <= address_one;
            addr_two_reg <= address_two;
            wdata_reg    <= data_in;
            busy         <= 1'b1;
            state_reg    <= (op_code == OP_WRITE) ? WR_ISSUE : RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          cnt_reg   <= CNT_W'(RD_LAT);
          state_reg <= RD_WAIT;
        end
        RD_WAIT: begin
          cnt_reg <= cnt_reg - 1'b1;
          // Count 1 marks the cycle in which mem_rdata carries the addressed word.
          if (cnt_reg == CNT_W'(1)) begin
            rbuf_reg <= mem_rdata;
            data_out <= mem_rdata;
            if (is_copy) begin
              state_reg <= WR_ISSUE;
            end else begin
              state_reg <= DONE;
              done      <= 1'b1;
            end
          end
        end
        WR_ISSUE: begin
          state_reg <= DONE;
          done      <= 1'b1;
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: four instances with RD_LAT 1..4, each on its own
// SRAM model, checked against a word-level memory model and cycle formulas.
module tb_sram_controller;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst_a  [N];
  logic        req_a    [N];
  logic [1:0]  op_a     [N];
  logic [6:0]  a1_a     [N];
  logic [6:0]  a2_a     [N];
  logic [31:0] din_a    [N];
  logic [31:0] dout_a   [N];
  logic        busy_a   [N];
  logic        done_a   [N];
  logic [6:0]  maddr_a  [N];
  logic        ren_a    [N];
  logic        wen_a    [N];
  logic [31:0] mwdata_a [N];
  logic [31:0] mrdata_a [N];

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem  [N][128];
  logic [31:0] model_dout [N];

  function automatic logic [31:0] init_val(int k, int a);
    logic [31:0] v;
    v = 32'(a + 1) * 32'h9E3779B1;
    return v ^ {4'(k), 28'h0};
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_inst
    logic [31:0] mem  [128];
    logic [31:0] pipe [4];

    initial begin
      for (int i = 0; i < 128; i++) mem[i] = init_val(gi, i);
    end

    // Word appears on mem_rdata exactly RD_LAT cycles after mem_ren; junk otherwise.
    always @(posedge clk) begin
      if (wen_a[gi]) mem[maddr_a[gi]] <= mwdata_a[gi];
      pipe[0] <= ren_a[gi] ? mem[maddr_a[gi]] : $urandom;
      for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
    end

    assign mrdata_a[gi] = pipe[gi];

    sram_controller #(.ADDR_W(7), .DATA_W(32), .RD_LAT(gi + 1)) dut (
      .clk        (clk),
      .n_rst      (n_rst_a[gi]),
      .req        (req_a[gi]),
      .op_code    (op_a[gi]),
      .address_one(a1_a[gi]),
      .address_two(a2_a[gi]),
      .data_in    (din_a[gi]),
      .data_out   (dout_a[gi]),
      .busy       (busy_a[gi]),
      .done       (done_a[gi]),
      .mem_addr   (maddr_a[gi]),
      .mem_ren    (ren_a[gi]),
      .mem_wen    (wen_a[gi]),
      .mem_wdata  (mwdata_a[gi]),
      .mem_rdata  (mrdata_a[gi])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request from T0, observed cycle by cycle until two cycles past the expected done.
  task automatic run_op(input int k, input logic [1:0] op, input logic [6:0] a1,
                        input logic [6:0] a2, input logic [31:0] d,
                        input logic [31:0] exp_dout, input bit hold_junk);
    int lat, exp_ren, exp_wen, exp_done, tmax;
    int ren_t, wen_t, done_t, extra, busy_bad;
    logic [6:0]  ren_addr, wen_addr;
    logic [31:0] wen_data, src_word;
    lat = k + 1;
    ren_t = -1; wen_t = -1; done_t = -1; extra = 0; busy_bad = 0;
    ren_addr = '0; wen_addr = '0; wen_data = '0;
    src_word = model_mem[k][a1];
    exp_ren  = (op == 2'b01 || op == 2'b11) ? 1 : -1;
    exp_wen  = (op == 2'b10) ? 1 : (op == 2'b11) ? 2 + lat : -1;
    exp_done = (op == 2'b01) ? 2 + lat : (op == 2'b10) ? 2 : (op == 2'b11) ? 3 + lat : -1;
    tmax     = (op == 2'b00) ? 4 : exp_done + 2;

    @(negedge clk);
    req_a[k] = 1'b1; op_a[k] = op; a1_a[k] = a1; a2_a[k] = a2; din_a[k] = d;
    for (int t = 1; t <= tmax; t++) begin
      @(negedge clk);
      if (t == 1) begin
        if (hold_junk) begin
          op_a[k] = 2'b10; a1_a[k] = 7'h01; din_a[k] = 32'hFFFFFFFF;
        end else begin
          req_a[k] = 1'b0;
        end
      end
      if (t == exp_done) req_a[k] = 1'b0;
      if (ren_a[k]) begin
        if (ren_t < 0) begin ren_t = t; ren_addr = maddr_a[k]; end
        else extra++;
      end
      if (wen_a[k]) begin
        if (wen_t < 0) begin wen_t = t; wen_addr = maddr_a[k]; wen_data = mwdata_a[k]; end
        else extra++;
      end
      if (done_a[k]) begin
        if (done_t < 0) done_t = t;
        else extra++;
      end
      if (ren_a[k] && wen_a[k]) extra++;
      if (!ren_a[k] && !wen_a[k] && (maddr_a[k] != 0 || mwdata_a[k] != 0)) extra++;
      if (t <= exp_done && !busy_a[k]) busy_bad++;
      if (t > exp_done && busy_a[k]) busy_bad++;
    end

    chk($sformatf("ren_cycle k%0d", k), 32'(ren_t), 32'(exp_ren));
    if (exp_ren > 0) chk($sformatf("ren_addr k%0d", k), 32'(ren_addr), 32'(a1));
    chk($sformatf("wen_cycle k%0d", k), 32'(wen_t), 32'(exp_wen));
    if (exp_wen > 0) begin
      chk($sformatf("wen_addr k%0d", k), 32'(wen_addr), 32'((op == 2'b10) ? a1 : a2));
      chk($sformatf("wen_data k%0d", k), wen_data, (op == 2'b10) ? d : src_word);
    end
    chk($sformatf("done_cycle k%0d", k), 32'(done_t), 32'(exp_done));
    chk($sformatf("extra_activity k%0d", k), 32'(extra), 32'd0);
    chk($sformatf("busy_window k%0d", k), 32'(busy_bad), 32'd0);

    case (op)
      2'b01: model_dout[k] = src_word;
      2'b10: model_mem[k][a1] = d;
      2'b11: begin model_dout[k] = src_word; model_mem[k][a2] = src_word; end
      default: ;
    endcase
    chk($sformatf("data_out k%0d", k), dout_a[k], exp_dout);
    $display("txn k=%0d lat=%0d op=%0d a1=%h a2=%h d=%h data_out=%h done@T%0d",
             k, lat, op, a1, a2, d, dout_a[k], done_t);
  endtask

  typedef struct {
    int          k;
    logic [1:0]  op;
    logic [6:0]  a1;
    logic [6:0]  a2;
    logic [31:0] d;
    logic [31:0] exp_dout;
    bit          hold;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int bad, wens, dones;
    logic [1:0]  rop;
    logic [6:0]  ra1, ra2;
    logic [31:0] rd, rexp;

    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 128; i++) model_mem[k][i] = init_val(k, i);
      model_dout[k] = '0;
      n_rst_a[k] = 1'b0; req_a[k] = 1'b1; op_a[k] = 2'b10;
      a1_a[k] = 7'h05; a2_a[k] = 7'h00; din_a[k] = 32'hAAAA5555;
    end

    // Reset held two cycles with a write request pending.
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) if (wen_a[k] === 1'b1) bad++;
    end
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_data_out k%0d", k), dout_a[k], 32'h0);
      chk($sformatf("rst_flags k%0d", k), {28'h0, busy_a[k], done_a[k], ren_a[k], wen_a[k]}, 32'h0);
      chk($sformatf("rst_bus k%0d", k), mwdata_a[k] | 32'(maddr_a[k]), 32'h0);
    end
    chk("rst_no_wen", 32'(bad), 32'd0);
    for (int k = 0; k < N; k++) begin
      n_rst_a[k] = 1'b1; req_a[k] = 1'b0; op_a[k] = 2'b00;
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) if (busy_a[k] !== 1'b0) bad++;
    end
    chk("post_rst_idle", 32'(bad), 32'd0);
    $display("txn reset: all instances idle");

    vecs.push_back('{0, 2'b10, 7'h05, 7'h00, 32'hDEADBEEF, 32'h00000000, 1'b0});
    vecs.push_back('{0, 2'b10, 7'h01, 7'h00, 32'h11111111, 32'h00000000, 1'b0});
    vecs.push_back('{0, 2'b01, 7'h05, 7'h00, 32'h00000000, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{0, 2'b00, 7'h05, 7'h00, 32'h00000000, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{0, 2'b01, 7'h05, 7'h00, 32'h00000000, 32'hDEADBEEF, 1'b1});
    vecs.push_back('{0, 2'b01, 7'h01, 7'h00, 32'h00000000, 32'h11111111, 1'b0});
    vecs.push_back('{0, 2'b10, 7'h00, 7'h00, 32'h00000000, 32'h11111111, 1'b0});
    vecs.push_back('{0, 2'b10, 7'h7F, 7'h00, 32'hFFFFFFFF, 32'h11111111, 1'b0});
    vecs.push_back('{0, 2'b01, 7'h00, 7'h00, 32'h00000000, 32'h00000000, 1'b0});
    vecs.push_back('{0, 2'b01, 7'h7F, 7'h00, 32'h00000000, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{0, 2'b10, 7'h00, 7'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{0, 2'b01, 7'h00, 7'h00, 32'h00000000, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{0, 2'b10, 7'h7F, 7'h00, 32'h00000000, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{0, 2'b01, 7'h7F, 7'h00, 32'h00000000, 32'h00000000, 1'b0});
    vecs.push_back('{2, 2'b10, 7'h10, 7'h00, 32'h12345678, 32'h00000000, 1'b0});
    vecs.push_back('{2, 2'b11, 7'h10, 7'h7F, 32'h00000000, 32'h12345678, 1'b0});
    vecs.push_back('{2, 2'b01, 7'h7F, 7'h00, 32'h00000000, 32'h12345678, 1'b0});
    vecs.push_back('{2, 2'b11, 7'h7F, 7'h7F, 32'h00000000, 32'h12345678, 1'b0});
    vecs.push_back('{2, 2'b01, 7'h7F, 7'h00, 32'h00000000, 32'h12345678, 1'b0});
    vecs.push_back('{1, 2'b10, 7'h20, 7'h00, 32'hCAFEF00D, 32'h00000000, 1'b0});
    vecs.push_back('{1, 2'b01, 7'h20, 7'h00, 32'h00000000, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{3, 2'b10, 7'h33, 7'h00, 32'hA5A5A5A5, 32'h00000000, 1'b0});
    vecs.push_back('{3, 2'b11, 7'h33, 7'h44, 32'h00000000, 32'hA5A5A5A5, 1'b0});
    vecs.push_back('{3, 2'b01, 7'h44, 7'h00, 32'h00000000, 32'hA5A5A5A5, 1'b0});

    foreach (vecs[i])
      run_op(vecs[i].k, vecs[i].op, vecs[i].a1, vecs[i].a2, vecs[i].d,
             vecs[i].exp_dout, vecs[i].hold);

    // Reset during RD_WAIT of a copy on the RD_LAT=2 instance.
    wens = 0; dones = 0;
    @(negedge clk);
    req_a[1] = 1'b1; op_a[1] = 2'b11; a1_a[1] = 7'h20; a2_a[1] = 7'h21;
    @(negedge clk);
    req_a[1] = 1'b0;
    chk("midrst_ren_T1", 32'(ren_a[1]), 32'd1);
    @(negedge clk);
    n_rst_a[1] = 1'b0;
    if (wen_a[1]) wens++;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      n_rst_a[1] = 1'b1;
      if (wen_a[1]) wens++;
      if (done_a[1] || busy_a[1]) dones++;
    end
    chk("midrst_no_wen", 32'(wens), 32'd0);
    chk("midrst_no_done", 32'(dones), 32'd0);
    chk("midrst_data_out", dout_a[1], 32'h0);
    model_dout[1] = '0;
    $display("txn k=1 reset mid-copy 20->21");
    run_op(1, 2'b01, 7'h21, 7'h00, 32'h0, model_mem[1][7'h21], 1'b0);

    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < 12; n++) begin
        rop = 2'($urandom_range(0, 3));
        ra1 = 7'($urandom);
        ra2 = 7'($urandom);
        rd  = $urandom;
        rexp = (rop == 2'b01 || rop == 2'b11) ? model_mem[k][ra1] : model_dout[k];
        run_op(k, rop, ra1, ra2, rd, rexp, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

SRAM-side responder for the datapath block. Accepts single-word requests (read, write, copy) carrying two 7-bit word addresses, a 32-bit write word and a 2-bit op code. Sequences them onto a single-port 128×32 synchronous SRAM with configurable read latency. Returns read data with a one-cycle completion pulse.

## Interface
- ADDR_W, 7, word address width (128 words)
- DATA_W, 32, data word width
- RD_LAT, 1, cycles from mem_ren asserted to mem_rdata valid; legal range 1..4
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  reset; synchronous, active-low
- req  input  1  request strobe from datapath, sampled only when busy=0
- op_code  input  2  00 nop, 01 read address_one, 10 write data_in to address_one, 11 copy address_one -> address_two
- address_one  input  ADDR_W  source/target address
- address_two  input  ADDR_W  copy destination address
- data_in  input  DATA_W  write data
- data_out  output  DATA_W  last word read (read or copy), registered
- busy  output  1  request in progress; high in every non-IDLE state
- done  output  1  one-cycle pulse at completion
- mem_addr  output  ADDR_W  SRAM address
- mem_ren  output  1  SRAM read enable
- mem_wen  output  1  SRAM write enable
- mem_wdata  output  DATA_W  SRAM write data
- mem_rdata  input  DATA_W  SRAM read data

## Operation
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE.
- IDLE, req=1, op 01 or 11: latch op_code, address_one, address_two, data_in; go to RD_ISSUE.
- IDLE, req=1, op 10: latch the same fields; go to WR_ISSUE.
- IDLE, req=1, op 00: ignored; stay IDLE; no busy, no done.
- RD_ISSUE, one cycle: mem_ren=1, mem_addr=latched address_one. Load latency counter with RD_LAT; go to RD_WAIT.
- RD_WAIT: decrement the counter each cycle. In the final wait cycle (counter=1), capture mem_rdata into the read buffer.
  - Read: also capture into data_out; go to DONE.
  - Copy: also capture into data_out; go to WR_ISSUE.
- WR_ISSUE, one cycle: mem_wen=1, mem_wdata = latched data_in (write) or read buffer (copy). mem_addr = latched address_one (write) or latched address_two (copy). Go to DONE.
- DONE, one cycle: done=1; go to IDLE.
- Copy with address_one == address_two still performs the full read then write.
- Outside RD_ISSUE/WR_ISSUE: mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0. mem_ren and mem_wen are never high together.
- req while busy=1 is ignored; it is not queued, and the latched fields do not change.
- data_out holds its value until the next read or copy completes; write does not alter it.

## Timing
- Reset (n_rst=0 at rising edge):
  - state=IDLE, counter=0
  - data_out=0, read buffer=0
  - busy=0, done=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0
- Reset mid-operation aborts the operation at that edge. No done is issued and no further SRAM access occurs. An SRAM write already issued stays done.
- Cycle numbering: T0 is the cycle in which req is sampled in IDLE.
- Read: mem_ren in T1. data_out valid and done=1 in T(2+RD_LAT). With RD_LAT=1, done in T3.
- Write: mem_wen in T1, done in T2.
- Copy: mem_ren in T1, mem_wen in T(2+RD_LAT), done in T(3+RD_LAT). With RD_LAT=1, done in T4.
- busy=1 from T1 through the done cycle inclusive.
- Earliest next accepted req: the cycle after done (IDLE again). Back-to-back writes therefore run every 3 cycles.
- All outputs are registered or decoded purely from state plus latched registers; no combinational path from req or op_code.

## Test plan
- Reset: n_rst=0 for 2 cycles with req=1, op 10 -> all outputs 0, no mem_wen; release; busy stays 0 until the next req.
- Write then read, RD_LAT=1:
  - write 0xDEADBEEF to 0x05 -> mem_wen in T1 with addr 0x05, done in T2.
  - read 0x05 -> mem_ren in T1, data_out=0xDEADBEEF and done in T3.
- Copy, RD_LAT=3: preload 0x10=0x12345678; copy 0x10 -> 0x7F -> mem_wen in T5 with addr 0x7F, wdata 0x12345678; done in T6; data_out=0x12345678; later read of 0x7F returns 0x12345678.
- Ignored requests:
  - op 00 with req=1 -> no busy, no done.
  - req (write 0x01, 0xFFFFFFFF) held during an active read -> no extra write; the read completes unchanged.
- Reset mid-copy, RD_LAT=2: n_rst=0 during RD_WAIT -> no mem_wen ever for that copy, no done, data_out=0.
- Boundaries:
  - write and read address 0x00 and 0x7F with 0x00000000 and 0xFFFFFFFF.
  - copy 0x7F -> 0x7F completes in 3+RD_LAT cycles with data unchanged.
